hack_cpu_mc: RTL and testbench

Parametrised multi-cycle successor to the Hack CPU core. It executes the Hack A/C instruction set at configurable data width and talks to instruction and data memories over request/ready handshakes, so memories with wait states can sit behind it. It also detects the canonical halt loop. It sits between the instruction ROM / data RAM interconnect and the top-level computer, replacing the single-cycle core.

---
 rtl/hack_pkg.sv | 26 ++
 rtl/hack_cpu_mc_if.sv | 31 +++
 rtl/hack_alu.sv | 27 ++
 rtl/hack_cpu_mc.sv | 111 +++++++++++
 tb/tb_hack_cpu_mc.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack cores: FSM state encoding, instruction field
// positions and the jump-condition helper.
package hack_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_HALT
    } state_t;

    localparam int A_BIT    = 12;
    localparam int COMP_LSB = 6;
    localparam int DEST_A   = 5;
    localparam int DEST_D   = 4;
    localparam int DEST_M   = 3;
    localparam int JMP_LT   = 2;
    localparam int JMP_EQ   = 1;
    localparam int JMP_GT   = 0;

    function automatic logic jump_taken(input logic [2:0] jmp, input logic zr, input logic ng);
        return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_cpu_mc_if.sv
// Instruction-fetch and data-memory request/ready bus between the core and
// the memory interconnect.
interface hack_cpu_mc_if #(
    parameter int WIDTH    = 16,
    parameter int PC_WIDTH = 15
);
    logic                instr_req;
    logic [PC_WIDTH-1:0] instr_addr;
    logic                instr_valid;
    logic [WIDTH-1:0]    instr_data;
    logic                mem_req;
    logic                mem_we;
    logic [WIDTH-1:0]    mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic                mem_ready;
    logic [WIDTH-1:0]    mem_rdata;

    modport master (
        output instr_req, instr_addr,
        input  instr_valid, instr_data,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_valid, instr_data,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/hack_alu.sv
// Combinational Hack ALU at arbitrary width; shared with the single-cycle core.
module hack_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);
    logic [WIDTH-1:0] x_z, x_n, y_z, y_n, res;

    assign x_z = zx ? '0 : x;
    assign x_n = nx ? ~x_z : x_z;
    assign y_z = zy ? '0 : y;
    assign y_n = ny ? ~y_z : y_z;
    assign res = f ? (x_n + y_n) : (x_n & y_n);
    assign out = no ? ~res : res;
    assign zr  = (out == '0);
    assign ng  = out[WIDTH-1];
endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH -> [READ] -> EXEC -> [WRITE] with request/ready
// memory handshakes and sticky detection of the jump-to-self halt loop.
module hack_cpu_mc
    import hack_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PC_WIDTH = 15
) (
    input  logic                clock,
    input  logic                reset,
    hack_cpu_mc_if.master       bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);
    state_t              state_q;
    logic [WIDTH-1:0]    ir_q, a_q, d_q, m_q, waddr_q, wres_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                halt_pend_q, halted_q;

    logic                is_c, take, halt_cond;
    logic [WIDTH-1:0]    alu_out, alu_y, a_d, d_d;
    logic [PC_WIDTH-1:0] pc_d;
    logic                alu_zr, alu_ng;

    assign is_c  = ir_q[WIDTH-1];
    assign alu_y = ir_q[A_BIT] ? m_q : a_q;

    hack_alu #(.WIDTH(WIDTH)) u_alu (
        .x  (d_q),
        .y  (alu_y),
        .zx (ir_q[COMP_LSB+5]),
        .nx (ir_q[COMP_LSB+4]),
        .zy (ir_q[COMP_LSB+3]),
        .ny (ir_q[COMP_LSB+2]),
        .f  (ir_q[COMP_LSB+1]),
        .no (ir_q[COMP_LSB]),
        .out(alu_out),
        .zr (alu_zr),
        .ng (alu_ng)
    );

    // All next values below use only pre-instruction A/D/M/pc.
    assign take      = is_c & jump_taken(ir_q[JMP_LT:JMP_GT], alu_zr, alu_ng);
    assign halt_cond = take && (a_q[PC_WIDTH-1:0] == pc_q);
    assign pc_d      = take ? a_q[PC_WIDTH-1:0] : pc_q + 1'b1;
    assign a_d       = !is_c ? {1'b0, ir_q[WIDTH-2:0]} : (ir_q[DEST_A] ? alu_out : a_q);
    assign d_d       = (is_c && ir_q[DEST_D]) ? alu_out : d_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            ir_q        <= '0;
            a_q         <= '0;
            d_q         <= '0;
            m_q         <= '0;
            pc_q        <= '0;
            waddr_q     <= '0;
            wres_q      <= '0;
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: if (bus.instr_valid) begin
                    ir_q    <= bus.instr_data;
                    state_q <= (bus.instr_data[WIDTH-1] && bus.instr_data[A_BIT]) ? S_READ : S_EXEC;
                end
                S_READ: if (bus.mem_ready) begin
                    m_q     <= bus.mem_rdata;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    a_q         <= a_d;
                    d_q         <= d_d;
                    pc_q        <= pc_d;
                    waddr_q     <= a_q;
                    wres_q      <= alu_out;
                    halt_pend_q <= halt_cond;
                    if (is_c && ir_q[DEST_M]) begin
                        state_q <= S_WRITE;
                    end else if (halt_cond) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_WRITE: if (bus.mem_ready) begin
                    if (halt_pend_q) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Fetch request is gated by reset so it drops the instant reset asserts.
    assign bus.instr_req  = reset && (state_q == S_FETCH);
    assign bus.instr_addr = pc_q;
    assign bus.mem_req    = (state_q == S_READ) || (state_q == S_WRITE);
    assign bus.mem_we     = (state_q == S_WRITE);
    assign bus.mem_addr   = (state_q == S_READ)  ? a_q :
                            (state_q == S_WRITE) ? waddr_q : '0;
    assign bus.mem_wdata  = (state_q == S_WRITE) ? wres_q : '0;
    assign pc             = pc_q;
    assign halted         = halted_q;
endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: acts as instruction ROM and data RAM, predicting every
// bus transaction from an instruction-level model of the Hack ISA.
module tb_hack_cpu_mc;
    logic        clock = 1'b0;
    logic        reset, sel;
    logic        tb_ivalid, tb_mready;
    logic [31:0] tb_idata, tb_mrdata;
    logic [14:0] pc0;
    logic [3:0]  pc1;
    logic        halted0, halted1;

    always #5 clock = ~clock;

    hack_cpu_mc_if #(.WIDTH(16), .PC_WIDTH(15)) bus0 ();
    hack_cpu_mc_if #(.WIDTH(24), .PC_WIDTH(4))  bus1 ();

    assign bus0.instr_valid = tb_ivalid & ~sel;
    assign bus0.instr_data  = tb_idata[15:0];
    assign bus0.mem_ready   = tb_mready & ~sel;
    assign bus0.mem_rdata   = tb_mrdata[15:0];
    assign bus1.instr_valid = tb_ivalid & sel;
    assign bus1.instr_data  = tb_idata[23:0];
    assign bus1.mem_ready   = tb_mready & sel;
    assign bus1.mem_rdata   = tb_mrdata[23:0];

    hack_cpu_mc #(.WIDTH(16), .PC_WIDTH(15)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.master), .pc(pc0), .halted(halted0)
    );
    hack_cpu_mc #(.WIDTH(24), .PC_WIDTH(4)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.master), .pc(pc1), .halted(halted1)
    );

    logic        o_ireq, o_mreq, o_mwe, o_halted;
    logic [31:0] o_iaddr, o_maddr, o_wdata, o_pc;
    always_comb begin
        o_ireq   = sel ? bus1.instr_req : bus0.instr_req;
        o_mreq   = sel ? bus1.mem_req   : bus0.mem_req;
        o_mwe    = sel ? bus1.mem_we    : bus0.mem_we;
        o_halted = sel ? halted1        : halted0;
        o_iaddr  = sel ? 32'(bus1.instr_addr) : 32'(bus0.instr_addr);
        o_maddr  = sel ? 32'(bus1.mem_addr)   : 32'(bus0.mem_addr);
        o_wdata  = sel ? 32'(bus1.mem_wdata)  : 32'(bus0.mem_wdata);
        o_pc     = sel ? 32'(pc1)             : 32'(pc0);
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model state
    int          mw, mpw;
    logic [31:0] mA, mD, mpc;
    logic [31:0] ram [logic [31:0]];

    function automatic logic [31:0] msk(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] ains(input int w, input logic [31:0] v);
        return v & msk(w - 1);
    endfunction

    // C-instruction with Hack fields from the low 13 bits and random filler in the ignored bits.
    function automatic logic [31:0] cins(input int w, input logic [31:0] fields);
        return (32'd1 << (w - 1)) | (fields & 32'h1FFF) | ($urandom & msk(w - 1) & ~32'h1FFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic predict(input logic [31:0] ins, output logic rd, output logic wr, output logic halt,
                           output logic [31:0] n_a, output logic [31:0] n_d, output logic [31:0] n_pc,
                           output logic [31:0] res);
        logic [31:0] m, x, y, f;
        logic        zr, ng, jmp;
        m = msk(mw);
        rd = 1'b0; wr = 1'b0; halt = 1'b0; res = '0;
        if (((ins >> (mw - 1)) & 32'd1) == 32'd0) begin
            n_a  = ins & msk(mw - 1);
            n_d  = mD;
            n_pc = (mpc + 1) & msk(mpw);
        end else begin
            f  = ins & 32'h1FFF;
            rd = f[12];
            if (rd && !ram.exists(mA)) ram[mA] = $urandom & m;
            x = mD;
            y = rd ? ram[mA] : mA;
            if (f[11]) x = '0;
            if (f[10]) x = ~x & m;
            if (f[9])  y = '0;
            if (f[8])  y = ~y & m;
            res = f[7] ? ((x + y) & m) : (x & y);
            if (f[6])  res = ~res & m;
            zr   = (res == 0);
            ng   = (res >= (32'd1 << (mw - 1)));
            jmp  = (f[2] && ng) || (f[1] && zr) || (f[0] && !ng && !zr);
            n_a  = f[5] ? res : mA;
            n_d  = f[4] ? res : mD;
            wr   = f[3];
            n_pc = jmp ? (mA & msk(mpw)) : ((mpc + 1) & msk(mpw));
            halt = jmp && ((mA & msk(mpw)) == mpc);
        end
    endtask

    // Serve one instruction with the given wait states; called at negedge+1 in FETCH.
    task automatic run(input logic [31:0] ins, input int fw, input int rw, input int ww, input string tag);
        logic        rd, wr, halt;
        logic [31:0] n_a, n_d, n_pc, res;
        predict(ins, rd, wr, halt, n_a, n_d, n_pc, res);
        for (int k = 0; k <= fw; k++) begin
            chk({tag, ".instr_req"}, 32'(o_ireq), 32'd1);
            chk({tag, ".instr_addr"}, o_iaddr, mpc);
            tb_ivalid = (k == fw);
            tb_idata  = ins;
            tb_mready = 1'($urandom_range(0, 1));
            tick;
        end
        tb_ivalid = 1'b0;
        tb_idata  = $urandom;
        if (rd) begin
            for (int k = 0; k <= rw; k++) begin
                chk({tag, ".rd_req"}, {o_mreq, o_mwe}, 32'd2);
                chk({tag, ".rd_addr"}, o_maddr, mA);
                tb_mready = (k == rw);
                tb_mrdata = (k == rw) ? ram[mA] : $urandom;
                tb_ivalid = 1'($urandom_range(0, 1));
                tick;
            end
        end
        chk({tag, ".exec_idle"}, {o_ireq, o_mreq}, 32'd0);
        tb_ivalid = 1'($urandom_range(0, 1));
        tb_mready = 1'($urandom_range(0, 1));
        tick;
        chk({tag, ".pc"}, o_pc, n_pc);
        if (wr) begin
            for (int k = 0; k <= ww; k++) begin
                chk({tag, ".wr_req"}, {o_mreq, o_mwe}, 32'd3);
                chk({tag, ".wr_addr"}, o_maddr, mA);
                chk({tag, ".wr_data"}, o_wdata, res);
                tb_mready = (k == ww);
                tb_ivalid = 1'($urandom_range(0, 1));
                tick;
            end
            ram[mA] = res;
        end
        tb_ivalid = 1'b0;
        tb_mready = 1'b0;
        mA  = n_a;
        mD  = n_d;
        mpc = n_pc;
        chk({tag, ".halted"}, 32'(o_halted), 32'(halt));
        chk({tag, ".next_req"}, 32'(o_ireq), 32'(!halt));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          c0;
        logic [31:0] ins, f13;
        logic        rd, wr, halt;
        logic [31:0] n_a, n_d, n_pc, res;

        reset = 1'b0; sel = 1'b0;
        tb_ivalid = 1'b0; tb_mready = 1'b0; tb_idata = '0; tb_mrdata = '0;
        mw = 16; mpw = 15; mA = '0; mD = '0; mpc = '0;

        repeat (3) tick;
        chk("rst.instr_req0", 32'(bus0.instr_req), 32'd0);
        chk("rst.mem_req0",   32'(bus0.mem_req),   32'd0);
        chk("rst.mem_addr0",  32'(bus0.mem_addr),  32'd0);
        chk("rst.pc0",        32'(pc0),            32'd0);
        chk("rst.halted0",    32'(halted0),        32'd0);
        chk("rst.instr_req1", 32'(bus1.instr_req), 32'd0);

        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rel.instr_req",  32'(o_ireq), 32'd1);
        chk("rel.instr_addr", o_iaddr,     32'd0);

        // @7; D=A; @3; M=D+1 with zero-wait memories
        c0 = cyc;
        run(ains(mw, 7),         0, 0, 0, "p1.a7");
        run(cins(mw, 32'hEC10),  0, 0, 0, "p1.dA");
        run(ains(mw, 3),         0, 0, 0, "p1.a3");
        run(cins(mw, 32'hE7C8),  0, 0, 0, "p1.mDp1");
        chk("p1.cycles", 32'(cyc - c0), 32'd9);
        chk("p1.pc_is_4", 32'(pc0), 32'd4);

        // D=M with three wait states, then M=D exposes D
        ram[3] = 32'd7;
        run(ains(mw, 3), 1, 0, 0, "rw.a3");
        c0 = cyc;
        run(cins(mw, 32'hFC10), 0, 3, 0, "rw.dM");
        chk("rw.cycles", 32'(cyc - c0), 32'd6);
        run(cins(mw, 32'hE308), 0, 0, 2, "rw.mD");

        // AM=M+1 writes at old A; M=A then exposes the new A
        run(ains(mw, 3),        0, 0, 0, "am.a3");
        c0 = cyc;
        run(cins(mw, 32'hFDE8), 0, 0, 0, "am.AMp1");
        chk("am.cycles", 32'(cyc - c0), 32'd4);
        run(cins(mw, 32'hEC08), 0, 0, 0, "am.mA");

        // Jumps
        run(cins(mw, 32'hEE90), 0, 0, 0, "j.dm1");
        run(ains(mw, 10),       0, 0, 0, "j.a10");
        run(cins(mw, 32'hE304), 0, 0, 0, "j.jlt");
        chk("j.jlt_pc", 32'(pc0), 32'd10);
        run(cins(mw, 32'hE301), 0, 0, 0, "j.jgt");
        chk("j.jgt_pc", 32'(pc0), 32'd11);

        // Random instruction stream with random wait states
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                ins = ains(mw, $urandom);
            end else begin
                f13 = $urandom & 32'h1FFF;
                ins = cins(mw, f13);
                predict(ins, rd, wr, halt, n_a, n_d, n_pc, res);
                if (halt) ins = ins & ~32'h7;
            end
            run(ins, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), "rnd");
        end

        // Jump-to-self halt loop
        run(ains(mw, (mpc + 1) & msk(mpw)), 0, 0, 0, "h.aself");
        run(cins(mw, 32'hEA87),             1, 0, 0, "h.jmp");
        repeat (4) tick;
        chk("h.halted_sticky", 32'(halted0),        32'd1);
        chk("h.no_req",        32'(bus0.instr_req), 32'd0);

        // 24-bit data, 4-bit pc instance
        sel = 1'b1;
        mw = 24; mpw = 4; mA = '0; mD = '0; mpc = '0;
        ram.delete();
        #1;
        run(ains(mw, 32'h7FFFFF), 0, 0, 0, "w.a7fffff");
        run(cins(mw, 32'h0C08),   0, 0, 0, "w.mA");
        for (int i = 0; i < 20 && mpc != 32'd15; i++) begin
            run(ains(mw, $urandom), $urandom_range(0, 1), 0, 0, "w.fill");
        end
        chk("w.pc_at_15", 32'(pc1), 32'd15);
        run(cins(mw, 32'h0C10), 0, 0, 0, "w.wrap");
        chk("w.pc_wrapped", 32'(pc1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
